// File: rtl/vsfx_pkg.sv
// Shared definitions for the VSFX (vector simple fixed-point) unit.
//   LANE_W   : width of one vector word lane
//   state_t  : sequencer states
//   SAT_POS / SAT_NEG : signed word saturation limits
package vsfx_pkg;

  localparam int LANE_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LANE_W-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [LANE_W-1:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/vsfx_vaddsws.sv
// Combinational 32-bit signed saturating word adder (one vaddsws lane).
// Ports:
//   a, b : signed word operands
//   sum  : saturated sum
//   sat  : high when the two's-complement sum overflowed and was clamped
module vsfx_vaddsws
  import vsfx_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] sum,
  output logic              sat
);

  // Returns {sat, result}. Overflow is only possible when both operands
  // share a sign and the wrapped sum has the opposite sign.
  function automatic logic [LANE_W:0] sat_add(input logic signed [LANE_W-1:0] x,
                                              input logic signed [LANE_W-1:0] y);
    logic signed [LANE_W-1:0] s;
    s = x + y;
    if (!x[LANE_W-1] && !y[LANE_W-1] && s[LANE_W-1])
      return {1'b1, SAT_POS};
    else if (x[LANE_W-1] && y[LANE_W-1] && !s[LANE_W-1])
      return {1'b1, SAT_NEG};
    else
      return {1'b0, s};
  endfunction

  logic signed [LANE_W-1:0] a_s;
  logic signed [LANE_W-1:0] b_s;
  logic        [LANE_W:0]   res;

  assign a_s = a;
  assign b_s = b;
  assign res = sat_add(a_s, b_s);
  assign sum = res[LANE_W-1:0];
  assign sat = res[LANE_W];

endmodule

// File: rtl/vsfx_vaddsws_seq.sv
// Multi-cycle 128-bit vaddsws: one shared saturating lane adder processes the
// word lanes one per cycle, word 0 (MSB word) first.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready       : operand handshake (vra, vrb)
//   flush                   : synchronous abort of an in-flight operation
//   out_valid/out_ready     : result handshake (vrt, sat)
//   vscr_sat, vscr_sat_clr  : sticky VSCR[SAT] and its clear (set wins)
module vsfx_vaddsws_seq
  import vsfx_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANE_W*NUM_LANES-1:0] vra,
  input  logic [LANE_W*NUM_LANES-1:0] vrb,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANE_W*NUM_LANES-1:0] vrt,
  output logic                        sat,
  output logic                        vscr_sat,
  input  logic                        vscr_sat_clr
);

  localparam int VEC_W = LANE_W * NUM_LANES;
  localparam int CNT_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_LANES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [VEC_W-1:0]   opa_q, opb_q;
  logic [VEC_W-1:0]   vrt_q;
  logic               sat_q;
  logic               vscr_q;

  logic [LANE_W-1:0]  lane_a, lane_b, lane_sum;
  logic               lane_sat;
  logic               accept, step, last, set_sticky;

  // Lane select: word i lives at the big-endian position NUM_LANES-1-i.
  always_comb begin
    lane_a = opa_q[LANE_W*(NUM_LANES-1-int'(cnt_q)) +: LANE_W];
    lane_b = opb_q[LANE_W*(NUM_LANES-1-int'(cnt_q)) +: LANE_W];
  end

  vsfx_vaddsws u_lane (
    .a   (lane_a),
    .b   (lane_b),
    .sum (lane_sum),
    .sat (lane_sat)
  );

  assign last = (cnt_q == LAST_LANE);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        // flush outranks a new operand pair
        if (in_valid && !flush) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The sticky bit is set on the edge that enters DONE, including the
  // final lane's own saturation which is not yet in sat_q.
  assign set_sticky = step && last && (sat_q || lane_sat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      vrt_q   <= '0;
      sat_q   <= 1'b0;
      vscr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opa_q <= vra;
        opb_q <= vrb;
        cnt_q <= '0;
        vrt_q <= '0;
        sat_q <= 1'b0;
      end else if (step) begin
        vrt_q[LANE_W*(NUM_LANES-1-int'(cnt_q)) +: LANE_W] <= lane_sum;
        sat_q <= sat_q | lane_sat;
        if (!last) cnt_q <= cnt_q + CNT_W'(1);
      end
      if (set_sticky)
        vscr_q <= 1'b1;
      else if (vscr_sat_clr)
        vscr_q <= 1'b0;
    end
  end

  assign in_ready  = (state_q == IDLE);
  // A flush in DONE abandons the result, so it is not offered that cycle.
  assign out_valid = (state_q == DONE) && !flush;
  assign vrt       = vrt_q;
  assign sat       = sat_q;
  assign vscr_sat  = vscr_q;

endmodule

// File: tb/tb_vsfx_vaddsws_seq.sv
module tb_vsfx_vaddsws_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] vra;
  logic [127:0] vrb;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] vrt;
  logic         sat;
  logic         vscr_sat;
  logic         vscr_sat_clr;

  int n_checks = 0;
  int n_fail   = 0;

  vsfx_vaddsws_seq #(.NUM_LANES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .vra          (vra),
    .vrb          (vrb),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .vrt          (vrt),
    .sat          (sat),
    .vscr_sat     (vscr_sat),
    .vscr_sat_clr (vscr_sat_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] exp_vrt;
    logic         exp_sat;
    logic         exp_vscr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Issue one operation and wait for out_valid; returns result and the
  // number of edges from the accept edge (inclusive) to out_valid.
  task automatic do_op(input logic [127:0] a, input logic [127:0] b,
                       output logic [127:0] r, output logic s, output int lat);
    @(negedge clk);
    chk("in_ready_before_issue", 128'(in_ready), 128'(1));
    vra = a;
    vrb = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = vrt;
    s = sat;
  endtask

  logic [127:0] r, r0;
  logic         s, s0;
  int           lat;

  initial begin
    vecs[0] = '{ {32'd1, 32'd2, 32'd3, 32'd4}, {32'd10, 32'd20, 32'd30, 32'd40},
                 {32'd11, 32'd22, 32'd33, 32'd44}, 1'b0, 1'b0 };
    vecs[1] = '{ {32'h0, 32'h0, 32'h7FFFFFF0, 32'h0}, {32'h0, 32'h0, 32'h00000100, 32'h0},
                 {32'h0, 32'h0, 32'h7FFFFFFF, 32'h0}, 1'b1, 1'b1 };
    vecs[2] = '{ {32'h80000000, 32'h0, 32'h0, 32'h0}, {32'hFFFFFFFF, 32'h0, 32'h0, 32'h0},
                 {32'h80000000, 32'h0, 32'h0, 32'h0}, 1'b1, 1'b1 };
    vecs[3] = '{ {32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00000005},
                 {32'h00000001, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFF0},
                 {32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF5}, 1'b0, 1'b1 };
    vecs[4] = '{ {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h40000000},
                 {32'h00000001, 32'h00000000, 32'h80000000, 32'h3FFFFFFF},
                 {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF}, 1'b1, 1'b1 };

    rst_n = 1'b0;
    in_valid = 1'b0;
    vra = '0;
    vrb = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    vscr_sat_clr = 1'b0;
    #12;
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_vrt",       vrt,             128'(0));
    chk("rst_sat",       128'(sat),       128'(0));
    chk("rst_vscr_sat",  128'(vscr_sat),  128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors, out_ready held high
    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].a, vecs[i].b, r, s, lat);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(5));
      chk($sformatf("vec%0d_vrt", i), r, vecs[i].exp_vrt);
      chk($sformatf("vec%0d_sat", i), 128'(s), 128'(vecs[i].exp_sat));
      chk($sformatf("vec%0d_vscr_sat", i), 128'(vscr_sat), 128'(vecs[i].exp_vscr));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid_after", i), 128'(out_valid), 128'(0));
      chk($sformatf("vec%0d_in_ready_after", i), 128'(in_ready), 128'(1));
    end

    // Clear alone drops the sticky bit
    vscr_sat_clr = 1'b1;
    @(posedge clk); #1;
    vscr_sat_clr = 1'b0;
    chk("clr_alone", 128'(vscr_sat), 128'(0));

    // Set/clear collision: clear during the last RUN cycle, set must win
    @(negedge clk);
    vra = vecs[2].a;
    vrb = vecs[2].b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    vscr_sat_clr = 1'b1;
    @(posedge clk); #1;
    vscr_sat_clr = 1'b0;
    chk("collide_out_valid", 128'(out_valid), 128'(1));
    chk("collide_vrt", vrt, vecs[2].exp_vrt);
    chk("collide_vscr_sat", 128'(vscr_sat), 128'(1));
    @(posedge clk); #1;
    vscr_sat_clr = 1'b1;
    @(posedge clk); #1;
    vscr_sat_clr = 1'b0;
    chk("collide_later_clr", 128'(vscr_sat), 128'(0));

    // Backpressure: DONE holds, in_valid ignored, one transfer on release
    out_ready = 1'b0;
    do_op(vecs[3].a, vecs[3].b, r0, s0, lat);
    chk("bp_latency", 128'(lat), 128'(5));
    chk("bp_vrt", r0, vecs[3].exp_vrt);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        vra = vecs[0].a;
        vrb = vecs[0].b;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("bp_hold_vrt_%0d", i), vrt, vecs[3].exp_vrt);
      chk($sformatf("bp_hold_sat_%0d", i), 128'(sat), 128'(0));
      chk($sformatf("bp_hold_valid_%0d", i), 128'(out_valid), 128'(1));
      chk($sformatf("bp_hold_in_ready_%0d", i), 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(out_valid), 128'(0));
    chk("bp_release_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    chk("bp_no_phantom_op", 128'(in_ready), 128'(1));

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    vra = vecs[0].a;
    vrb = vecs[0].b;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("idle_flush_in_ready", 128'(in_ready), 128'(1));
    repeat (5) begin @(posedge clk); #1; end
    chk("idle_flush_no_valid", 128'(out_valid), 128'(0));

    // Flush during lane 1 of a saturating op: no result, sticky untouched
    @(negedge clk);
    vra = {32'h0, 32'h0, 32'h0, 32'h7FFFFFFF};
    vrb = {32'h0, 32'h0, 32'h0, 32'h00000001};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("flush_quiet_%0d", i), 128'(out_valid), 128'(0));
    end
    chk("flush_vscr_sat", 128'(vscr_sat), 128'(0));
    do_op(vecs[0].a, vecs[0].b, r, s, lat);
    chk("post_flush_latency", 128'(lat), 128'(5));
    chk("post_flush_vrt", r, vecs[0].exp_vrt);
    chk("post_flush_sat", 128'(s), 128'(0));
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN (with vscr_sat set beforehand)
    do_op(vecs[1].a, vecs[1].b, r, s, lat);
    chk("pre_rst_vscr_sat", 128'(vscr_sat), 128'(1));
    @(posedge clk); #1;
    @(negedge clk);
    vra = vecs[4].a;
    vrb = vecs[4].b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  128'(in_ready),  128'(1));
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_vrt",       vrt,             128'(0));
    chk("mid_rst_sat",       128'(sat),       128'(0));
    chk("mid_rst_vscr_sat",  128'(vscr_sat),  128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do_op(vecs[0].a, vecs[0].b, r, s, lat);
    chk("post_rst_latency", 128'(lat), 128'(5));
    chk("post_rst_vrt", r, vecs[0].exp_vrt);
    chk("post_rst_sat", 128'(s), 128'(0));
    chk("post_rst_vscr_sat", 128'(vscr_sat), 128'(0));
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vsfx_vaddsws_seq.md
# vsfx_vaddsws_seq

Multi-cycle sequencer that performs a full 128-bit AltiVec vaddsws (vector add signed word saturate) using one shared 32-bit saturating lane adder. It accepts an operand pair over a valid/ready handshake and feeds the four word lanes through the adder one per cycle. It then returns the assembled result together with a per-instruction SAT flag and a sticky VSCR[SAT] bit. The block sits in the VSFX (vector simple fixed-point) unit between issue and writeback.

## Interface
- NUM_LANES, 4, number of 32-bit word lanes; vector width is 32*NUM_LANES.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- vra  in  32*NUM_LANES  operand A; word 0 is bits [127:96] (big-endian element order).
- vrb  in  32*NUM_LANES  operand B, same lane order.
- flush  in  1  synchronous abort of any in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- vrt  out  32*NUM_LANES  saturated sum, same lane order.
- sat  out  1  at least one lane saturated in this result.
- vscr_sat  out  1  sticky VSCR[SAT].
- vscr_sat_clr  in  1  clears the sticky bit (mtvscr path).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid is high, vra/vrb are captured into operand registers, the lane counter is set to 0, the result and the sat accumulator are cleared, and the block goes to RUN.
- RUN: the lane adder receives the operand words selected by the lane counter. Its 32-bit result is written into the matching vrt word, and its sat output is ORed into the sat accumulator. The counter increments. After lane NUM_LANES-1 the block goes to DONE. in_ready=0.
- Lane arithmetic uses a 32-bit two's-complement sum.
  - Positive overflow (both operands non-negative, sum negative) gives 32'h7FFFFFFF with sat=1.
  - Negative overflow (both operands negative, sum non-negative) gives 32'h80000000 with sat=1.
  - Otherwise the lane result is the wrapped sum with sat=0.
- DONE: out_valid=1, and vrt/sat are held stable. On out_valid and out_ready, the block goes to IDLE. On the cycle DONE is entered, vscr_sat is set if the accumulated sat is 1.
- vscr_sat_clr clears vscr_sat. If a clear and a set occur in the same cycle, the set wins.
- flush in RUN or DONE: return to IDLE next cycle, with no out_valid and no vscr_sat update. flush in IDLE has no effect. In IDLE, flush has priority over in_valid, so the operand pair is not accepted.
- Lane counter width is clog2(NUM_LANES). The counter never wraps past NUM_LANES-1.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, vrt=0, sat=0, vscr_sat=0, and counter and operand registers=0.
- Reset asserted mid-operation discards everything immediately (asynchronously). No partial result is emitted.
- Latency: accept edge T, lanes processed in cycles T+1..T+NUM_LANES, out_valid high from cycle T+NUM_LANES+1.
- For NUM_LANES=4, out_valid rises 5 cycles after the accept edge.
- Minimum initiation interval is NUM_LANES+2 cycles: accept, NUM_LANES RUN cycles, one DONE cycle with out_ready=1, then back to IDLE.
- If out_ready is low, DONE holds indefinitely and in_ready stays 0.
- in_ready depends only on state. It is a registered-state decode with no combinational path from out_ready.

## Structure
- Shared package vsfx_pkg holds:
  - LANE_W=32.
  - the state enum {IDLE, RUN, DONE}.
  - the saturation constants SAT_POS=32'h7FFFFFFF and SAT_NEG=32'h80000000.
- One sub-module is instantiated: the existing vsfx_vaddsws lane adder, combinational, 32-bit in/out plus sat.
- The sequencer contains the FSM, the lane counter, the operand and result registers, and the sticky VSCR bit.

## Test plan
- Plain add: vra={1,2,3,4}, vrb={10,20,30,40}, out_ready=1 → out_valid at T+5, vrt={11,22,33,44}, sat=0, vscr_sat=0.
- Positive saturation in lane 2: vra word2=32'h7FFFFFF0, vrb word2=32'h00000100, other lanes 0 → vrt word2=32'h7FFFFFFF, other words 0, sat=1, vscr_sat=1 from cycle T+5. A following clean operation gives sat=0 while vscr_sat stays 1.
- Negative saturation plus clear collision: lane0 32'h80000000+32'hFFFFFFFF → 32'h80000000, sat=1. vscr_sat_clr is asserted in the cycle DONE is entered, and vscr_sat still reads 1. A later clear alone gives 0.
- Backpressure: out_ready=0 for 10 cycles → vrt/sat stable, in_ready=0, and an in_valid pulse is ignored. Releasing out_ready gives one transfer, then in_ready=1.
- Flush at the RUN cycle for lane 1 → no out_valid, vscr_sat unchanged, in_ready=1 next cycle. A new operation then completes correctly.
- rst_n pulsed low mid-RUN → all outputs at reset values immediately. After release, a new operation completes with latency 5.
